// File: rtl/decode_pkg.sv
// Shared decode definitions: RV opcodes, immediate formats and the immediate generator.
package decode_pkg;

  localparam logic [6:0] OP_IMM = 7'b0010011;
  localparam logic [6:0] LOAD   = 7'b0000011;
  localparam logic [6:0] JALR   = 7'b1100111;
  localparam logic [6:0] STORE  = 7'b0100011;
  localparam logic [6:0] BRANCH = 7'b1100011;
  localparam logic [6:0] LUI    = 7'b0110111;
  localparam logic [6:0] AUIPC  = 7'b0010111;
  localparam logic [6:0] JAL    = 7'b1101111;

  typedef enum logic [2:0] {
    IMM_I,
    IMM_S,
    IMM_B,
    IMM_U,
    IMM_J,
    IMM_NONE
  } imm_type_e;

  function automatic imm_type_e get_imm_type(input logic [6:0] opcode);
    imm_type_e t;
    case (opcode)
      OP_IMM, LOAD, JALR: t = IMM_I;
      STORE:              t = IMM_S;
      BRANCH:             t = IMM_B;
      LUI, AUIPC:         t = IMM_U;
      JAL:                t = IMM_J;
      default:            t = IMM_NONE;
    endcase
    return t;
  endfunction

  // 32-bit sign-extended immediate; the stage widens it to XLEN.
  function automatic logic [31:0] gen_imm(input logic [31:0] inst);
    logic [31:0] imm;
    case (get_imm_type(inst[6:0]))
      IMM_I:   imm = {{20{inst[31]}}, inst[31:20]};
      IMM_S:   imm = {{20{inst[31]}}, inst[31:25], inst[11:7]};
      IMM_B:   imm = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
      IMM_U:   imm = {inst[31:12], 12'b0};
      IMM_J:   imm = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
      default: imm = '0;
    endcase
    return imm;
  endfunction

endpackage

// File: rtl/decode_regfile.sv
// Architectural register file: two async read ports, one write port, x0 hardwired to zero,
// async active-low clear.
module decode_regfile
  import decode_pkg::*;
#(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned NREG   = 32,
  localparam int unsigned REG_AW = $clog2(NREG)
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [REG_AW-1:0] rs1_addr_i,
  input  logic [REG_AW-1:0] rs2_addr_i,
  output logic [XLEN-1:0]   rs1_data_o,
  output logic [XLEN-1:0]   rs2_data_o,
  input  logic              we_i,
  input  logic [REG_AW-1:0] waddr_i,
  input  logic [XLEN-1:0]   wdata_i
);

  logic [XLEN-1:0] regs_q [NREG];

  // Writeback into the array; x0 is never written.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
    end else if (we_i && (waddr_i != '0)) begin
      regs_q[waddr_i] <= wdata_i;
    end
  end

  assign rs1_data_o = (rs1_addr_i == '0) ? '0 : regs_q[rs1_addr_i];
  assign rs2_data_o = (rs2_addr_i == '0) ? '0 : regs_q[rs2_addr_i];

endmodule

// File: rtl/decode_stage_pipe.sv
// Handshaked decode stage: register file read, immediate generation and ID/EX register
// with flush and refresh of held operands on writeback.
// Build option: define DECODE_WB_BYPASS_EN to forward a same-cycle writeback into the
// operands captured on accept.
module decode_stage_pipe
  import decode_pkg::*;
#(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned NREG   = 32,
  localparam int unsigned REG_AW = $clog2(NREG)
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic [31:0]       i_instruct,
  input  logic [XLEN-1:0]   i_pc,
  input  logic              i_flush,
  input  logic              i_rd_wren,
  input  logic [REG_AW-1:0] i_rd_addr,
  input  logic [XLEN-1:0]   i_rd_data,
  output logic              o_valid,
  input  logic              i_ready,
  output logic [XLEN-1:0]   o_rs1_data,
  output logic [XLEN-1:0]   o_rs2_data,
  output logic [XLEN-1:0]   o_imme_value,
  output logic [REG_AW-1:0] o_rs1_addr,
  output logic [REG_AW-1:0] o_rs2_addr,
  output logic [REG_AW-1:0] o_rd_addr,
  output logic [XLEN-1:0]   o_pc,
  output logic [31:0]       o_instruct
);

  logic [REG_AW-1:0] rs1_addr, rs2_addr, rd_addr;
  logic [XLEN-1:0]   rf_rs1, rf_rs2, rs1_sel, rs2_sel, imm_xlen;
  logic              accept;

  logic              valid_q;
  logic [XLEN-1:0]   rs1_data_q, rs2_data_q, imm_q, pc_q;
  logic [REG_AW-1:0] rs1_addr_q, rs2_addr_q, rd_addr_q;
  logic [31:0]       instruct_q;

  // Upper address bits are dropped when NREG is 16.
  assign rs1_addr = i_instruct[15 +: REG_AW];
  assign rs2_addr = i_instruct[20 +: REG_AW];
  assign rd_addr  = i_instruct[7 +: REG_AW];

  decode_regfile #(
    .XLEN (XLEN),
    .NREG (NREG)
  ) u_regfile (
    .clk_i      (i_clk),
    .rst_ni     (i_rst),
    .rs1_addr_i (rs1_addr),
    .rs2_addr_i (rs2_addr),
    .rs1_data_o (rf_rs1),
    .rs2_data_o (rf_rs2),
    .we_i       (i_rd_wren),
    .waddr_i    (i_rd_addr),
    .wdata_i    (i_rd_data)
  );

`ifdef DECODE_WB_BYPASS_EN
  assign rs1_sel = (i_rd_wren && (i_rd_addr == rs1_addr) && (rs1_addr != '0)) ? i_rd_data
                                                                              : rf_rs1;
  assign rs2_sel = (i_rd_wren && (i_rd_addr == rs2_addr) && (rs2_addr != '0)) ? i_rd_data
                                                                              : rf_rs2;
`else
  // Pre-write value; upstream hazard logic stalls a cycle for write-then-read.
  assign rs1_sel = rf_rs1;
  assign rs2_sel = rf_rs2;
`endif

  assign imm_xlen = XLEN'($signed(gen_imm(i_instruct)));

  assign o_ready = !valid_q || i_ready;
  assign accept  = i_valid && o_ready;

  // Valid flag: flush beats accept beats drain.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      valid_q <= 1'b0;
    end else if (i_flush) begin
      valid_q <= 1'b0;
    end else if (accept) begin
      valid_q <= 1'b1;
    end else if (i_ready) begin
      valid_q <= 1'b0;
    end
  end

  // Payload: capture on accept, otherwise refresh held operands from writeback.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      rs1_data_q <= '0;
      rs2_data_q <= '0;
      imm_q      <= '0;
      pc_q       <= '0;
      rs1_addr_q <= '0;
      rs2_addr_q <= '0;
      rd_addr_q  <= '0;
      instruct_q <= '0;
    end else if (!i_flush && accept) begin
      rs1_data_q <= rs1_sel;
      rs2_data_q <= rs2_sel;
      imm_q      <= imm_xlen;
      pc_q       <= i_pc;
      rs1_addr_q <= rs1_addr;
      rs2_addr_q <= rs2_addr;
      rd_addr_q  <= rd_addr;
      instruct_q <= i_instruct;
    end else if (valid_q && !i_ready && i_rd_wren) begin
      if ((i_rd_addr == rs1_addr_q) && (rs1_addr_q != '0)) rs1_data_q <= i_rd_data;
      if ((i_rd_addr == rs2_addr_q) && (rs2_addr_q != '0)) rs2_data_q <= i_rd_data;
    end
  end

  assign o_valid      = valid_q;
  assign o_rs1_data   = rs1_data_q;
  assign o_rs2_data   = rs2_data_q;
  assign o_imme_value = imm_q;
  assign o_rs1_addr   = rs1_addr_q;
  assign o_rs2_addr   = rs2_addr_q;
  assign o_rd_addr    = rd_addr_q;
  assign o_pc         = pc_q;
  assign o_instruct   = instruct_q;

endmodule
